// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory stage.
// One request in flight at a time: accept in IDLE, wait in BUSY, present the
// response in RESP until the requester takes it. The memory access itself
// (store commit or load snapshot) happens on the acceptance edge, so BUSY is
// pure latency.
//
// Handshake contract: a request transfers on a rising edge where
// req_valid_i && req_ready_o; a response transfers on a rising edge where
// rsp_valid_o && rsp_ready_i. Once raised, rsp_valid_o, rsp_rdata_o and
// rsp_err_o stay stable until that transfer.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_ext_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  // BUSY counts down from this value; unused when LATENCY is 1.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [WORDS];

  logic [ADDR_WIDTH-3:0]   word_idx;
  logic [1:0]              lane;
  logic                    accept;
  logic                    access_err;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_shift;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   wr_lanes;
  logic [3:0]              wr_be;

  // Address bits above the decoded range alias onto the same storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr_i[31:ADDR_WIDTH];

  assign word_idx = req_addr_i[ADDR_WIDTH-1:2];
  assign lane     = req_addr_i[1:0];
  assign accept   = (state_q == S_IDLE) && req_valid_i;
  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign dbg_state_o = state_q;

  // Decode size/alignment into byte enables, replicated store lanes and the extended load value.
  always_comb begin
    access_err = 1'b0;
    wr_be      = 4'b0000;
    wr_lanes   = '0;
    load_val   = '0;
    unique case (req_type_i)
      2'b00: begin
        wr_be    = 4'b0001 << lane;
        wr_lanes = {4{req_wdata_i[7:0]}};
        load_val = {{24{req_sign_ext_i & rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        access_err = lane[0];
        wr_be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{req_wdata_i[15:0]}};
        load_val   = {{16{req_sign_ext_i & rd_shift[15]}}, rd_shift[15:0]};
      end
      2'b10: begin
        access_err = (lane != 2'b00);
        wr_be      = 4'b1111;
        wr_lanes   = req_wdata_i;
        load_val   = rd_word;
      end
      default: begin
        access_err = 1'b1;
      end
    endcase
  end

  // Next-state logic; the response payload is captured only when a request is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          err_d   = access_err;
          rdata_d = (access_err || req_write_i) ? '0 : load_val;
          if (LATENCY > 1) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset drops any pending transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array commits aligned stores on the acceptance edge; never reset.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

endmodule
